dm_arbiter: RTL

- Shares the single-port data memory between the M-stage CPU port and one DMA requester port.
- CPU has fixed priority. A starvation counter forces a DMA grant after STARVE_MAX denied cycles, and the CPU pipeline is stalled for that cycle.
- Generates the memory-side address, write data, byte enables and strobes.
- Performs address range checking.

---
 rtl/dm_arbiter_pkg.sv | 16 +
 rtl/dm_arbiter_if.sv | 48 ++++
 rtl/dm_starve_cnt.sv | 44 ++++
 rtl/dm_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// Shared constants, FSM state type and range helper for the data-memory arbiter.
package dm_arbiter_pkg;

  localparam logic [31:0] ZERO         = 32'h0000_0000;
  localparam logic [31:0] DMA_TRACE_PC = 32'hFFFF_FFFF;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } arb_state_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
    return {2'b00, addr[31:2]} < words;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Bus bundle between the CPU M-stage, the DMA requester, the data memory and the arbiter.
interface dm_arbiter_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_pc;
  logic [31:0] cpu_rd;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wd;
  logic        dma_gnt;
  logic [31:0] dma_rd;
  logic        dma_valid;

  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_be;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rd;

  logic        err_oob;

  // Requesters and memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be, cpu_pc,
    output dma_req, dma_we, dma_addr, dma_wd,
    output mem_rd,
    input  cpu_rd, cpu_stall, dma_gnt, dma_rd, dma_valid,
    input  mem_addr, mem_wd, mem_be, mem_we, mem_re, err_oob
  );

  // Arbiter side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, cpu_be, cpu_pc,
    input  dma_req, dma_we, dma_addr, dma_wd,
    input  mem_rd,
    output cpu_rd, cpu_stall, dma_gnt, dma_rd, dma_valid,
    output mem_addr, mem_wd, mem_be, mem_we, mem_re, err_oob
  );

endinterface

// File: rtl/dm_starve_cnt.sv
// DMA starvation counter: counts consecutive denied DMA cycles and flags FORCE at STARVE_MAX.
module dm_starve_cnt
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dma_req,
  input  logic       dma_gnt,
  output arb_state_e state
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  arb_state_e       state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= NORMAL;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // state_q is a registered image of (cnt_q == STARVE_MAX), so the grant path sees no counter compare
  always_comb begin
    cnt_d   = '0;
    state_d = NORMAL;
    if (dma_req && !dma_gnt) begin
      if (cnt_q >= CNT_W'(STARVE_MAX))
        cnt_d = CNT_W'(STARVE_MAX);
      else
        cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CNT_W'(STARVE_MAX))
      state_d = FORCE;
  end

  assign state = state_q;

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: fixed CPU priority with starvation-forced DMA grants and range checking.
// Optional write trace enabled by defining DM_TRACE_EN.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 3072,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 4
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);

  arb_state_e  state;
  logic        force_dma;
  logic        cpu_gnt;
  logic        dma_gnt;
  logic        granted;
  logic        acc_we;
  logic        in_range;
  logic [31:0] acc_addr;
  logic [31:0] dma_rd_q;
  logic        dma_valid_q;
  logic        err_q;

  dm_starve_cnt #(
    .STARVE_MAX(STARVE_MAX),
    .CNT_W     (CNT_W)
  ) u_starve_cnt (
    .clk    (clk),
    .reset  (reset),
    .dma_req(bus.dma_req),
    .dma_gnt(dma_gnt),
    .state  (state)
  );

  // FORCE only takes effect while DMA is still asking; otherwise the CPU keeps priority
  always_comb begin
    force_dma = (state == FORCE) && bus.dma_req;
    cpu_gnt   = !reset && bus.cpu_req && !force_dma;
    dma_gnt   = !reset && bus.dma_req && !cpu_gnt;
    granted   = cpu_gnt || dma_gnt;
    acc_addr  = dma_gnt ? bus.dma_addr : bus.cpu_addr;
    acc_we    = dma_gnt ? bus.dma_we : bus.cpu_we;
    in_range  = addr_in_range(acc_addr, MEM_WORDS);
  end

  assign bus.dma_gnt   = dma_gnt;
  assign bus.cpu_stall = !reset && force_dma && bus.cpu_req;
  assign bus.mem_addr  = {acc_addr[31:2], 2'b00};
  assign bus.mem_wd    = dma_gnt ? bus.dma_wd : bus.cpu_wd;
  assign bus.mem_be    = dma_gnt ? 4'hF : bus.cpu_be;
  assign bus.mem_we    = granted && acc_we && in_range;
  assign bus.mem_re    = granted && !acc_we;
  assign bus.cpu_rd    = (cpu_gnt && !bus.cpu_we && in_range) ? bus.mem_rd : ZERO;

  always_ff @(posedge clk) begin
    if (reset) begin
      dma_rd_q    <= ZERO;
      dma_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      dma_valid_q <= dma_gnt;
      if (dma_gnt && !bus.dma_we)
        dma_rd_q <= in_range ? bus.mem_rd : ZERO;
      if (granted && !in_range)
        err_q <= 1'b1;
    end
  end

  assign bus.dma_rd    = dma_rd_q;
  assign bus.dma_valid = dma_valid_q;
  assign bus.err_oob   = err_q;

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (bus.mem_we)
      $display("%d@%h: *%h <= %h", $time, dma_gnt ? DMA_TRACE_PC : bus.cpu_pc,
               bus.mem_addr, bus.mem_wd);
  end
`endif

endmodule
